// File: rtl/fpnr_pkg.sv
// Shared constants and the status-flag bundle for the single-precision normalize/round stage.
package fpnr_pkg;

  localparam int BIAS    = 127;
  localparam int FRAC_W  = 23;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;

  localparam logic [30:0] INF_MAG = 31'h7F800000;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpnr_flags_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-one detector: index of the most significant set bit, plus an all-zero indication.
module fp_lzc #(
  parameter int W = 48
) (
  input  logic [W-1:0]         data_i,
  output logic [$clog2(W)-1:0] msb_o,
  output logic                 zero_o
);

  localparam int IW = $clog2(W);

  always_comb begin
    msb_o = '0;
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) msb_o = IW'(i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_normalize_round.sv
// Three-stage normalize / round-to-nearest-even / pack into IEEE-754 single.
// Define FPNR_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to zero.
module fp_normalize_round
  import fpnr_pkg::*;
#(
  parameter int MW = 48,
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_mant,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic          out_overflow,
  output logic          out_underflow,
  output logic          out_inexact
);

  localparam int PW = $clog2(MW);
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] E_MAX  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  // Valid/ready: a word moves when valid && ready; all stages advance together
  // whenever the output slot is empty or being drained this cycle.
  logic adv;
  logic v1_q, v2_q, v3_q;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;

  // Stage 1: leading-one position registered alongside the operands.
  logic [PW-1:0] p_d;
  logic          zero_d;
  logic          s1_sign_q, s1_sticky_q, s1_zero_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW-1:0] s1_mant_q;
  logic [PW-1:0] s1_p_q;

  fp_lzc #(.W(MW)) u_lzc (
    .data_i (in_mant),
    .msb_o  (p_d),
    .zero_o (zero_d)
  );

  // Stage 2: shift the leading one up to bit MW-1 (dropped) and split frac/guard/sticky.
  logic [PW-1:0]          lsh;
  logic [MW-2:0]          norm;
  logic signed [XW-1:0]   e2_d;
  logic [FRAC_W-1:0]      frac2_d;
  logic                   g2_d, st2_d;
  logic                   s2_sign_q, s2_zero_q, s2_g_q, s2_st_q;
  logic signed [XW-1:0]   s2_e_q;
  logic [FRAC_W-1:0]      s2_frac_q;

  assign lsh     = PW'(MW-1) - s1_p_q;
  assign norm    = (MW-1)'(s1_mant_q << lsh);
  assign e2_d    = XW'($signed(s1_exp_q)) + XW'(s1_p_q) - XW'(MW-2);
  assign frac2_d = norm[MW-2 -: FRAC_W];
  assign g2_d    = norm[MW-FRAC_W-2];
  assign st2_d   = (|norm[MW-FRAC_W-3:0]) | s1_sticky_q;

  // Stage 3: round to nearest even, then classify and pack.
  logic                 r_up;
  logic [FRAC_W:0]      rsum;
  logic signed [XW-1:0] e3;
  logic [31:0]          res_d, res_q;
  fpnr_flags_t          flg_d, flags_q;

  assign r_up = s2_g_q & (s2_st_q | s2_frac_q[0]);
  assign rsum = {1'b0, s2_frac_q} + (FRAC_W+1)'(r_up);
  assign e3   = s2_e_q + XW'(rsum[FRAC_W]);

`ifdef FPNR_SUBNORMAL_EN
  // Denormalize the hidden-one significand; guard rides along so no double rounding.
  logic signed [XW-1:0] sh_full;
  logic [4:0]           sh_sat;
  logic [FRAC_W+26:0]   ext;
  logic                 sub_g, sub_st, sub_inx;
  logic [FRAC_W:0]      ssum;

  assign sh_full = XW'(1) - s2_e_q;
  assign sh_sat  = (sh_full > XW'(26)) ? 5'd26 : sh_full[4:0];
  assign ext     = (FRAC_W+27)'({1'b1, s2_frac_q, s2_g_q, 26'b0} >> sh_sat);
  assign sub_g   = ext[26];
  assign sub_st  = (|ext[25:0]) | s2_st_q;
  assign sub_inx = sub_g | sub_st;
  assign ssum    = {1'b0, ext[FRAC_W+26:27]} + (FRAC_W+1)'(sub_g & (sub_st | ext[27]));
`endif

  always_comb begin
    res_d = {s2_sign_q, 31'b0};
    flg_d = '0;
    if (s2_zero_q) begin
      res_d = {s2_sign_q, 31'b0};
    end else if (e3 >= E_MAX) begin
      res_d          = {s2_sign_q, INF_MAG};
      flg_d.overflow = 1'b1;
      flg_d.inexact  = 1'b1;
    end
`ifdef FPNR_SUBNORMAL_EN
    else if (s2_e_q <= E_ZERO) begin
      res_d           = {s2_sign_q, 7'b0, ssum};
      flg_d.underflow = sub_inx;
      flg_d.inexact   = sub_inx;
    end
`else
    else if (e3 <= E_ZERO) begin
      flg_d.underflow = 1'b1;
      flg_d.inexact   = 1'b1;
    end
`endif
    else begin
      res_d         = {s2_sign_q, e3[EXP_W-1:0], rsum[FRAC_W-1:0]};
      flg_d.inexact = s2_g_q | s2_st_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_p_q      <= '0;
      v2_q        <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_g_q      <= 1'b0;
      s2_st_q     <= 1'b0;
      s2_e_q      <= '0;
      s2_frac_q   <= '0;
      v3_q        <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= in_sign;
        s1_sticky_q <= in_sticky;
        s1_zero_q   <= zero_d;
        s1_exp_q    <= in_exp;
        s1_mant_q   <= in_mant;
        s1_p_q      <= p_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_g_q    <= g2_d;
        s2_st_q   <= st2_d;
        s2_e_q    <= e2_d;
        s2_frac_q <= frac2_d;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        res_q   <= res_d;
        flags_q <= flg_d;
      end
    end
  end

  assign out_result    = res_q;
  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
  assign out_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed corner cases plus randomized traffic against an arithmetic model.
module tb_fp_normalize_round;

  localparam int MW = 48;
  localparam int EW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sign, in_sticky;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic          out_valid, out_ready;
  logic [31:0]   out_result;
  logic          out_overflow, out_underflow, out_inexact;

  int total = 0;
  int bad   = 0;
  bit stim_done;

  // {result, overflow, underflow, inexact}
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];

  always #5 clk = ~clk;

  fp_normalize_round #(.MW(MW), .EW(EW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_sticky     (in_sticky),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  // Outputs that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back({out_result, out_overflow, out_underflow, out_inexact});
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Value = (-1)^s * m * 2^(ex-127-46), rounded RNE onto the single-precision grid.
  function automatic logic [34:0] model(input logic s, input logic [EW-1:0] ex,
                                        input logic [MW-1:0] m, input logic st);
    int e_in, p, k, e;
    longint unsigned mm, q, rem, half;
    logic inx, up;
    if (m == '0) return {s, 31'b0, 3'b000};
    mm   = 64'(m);
    e_in = int'($signed(ex));
    p    = $clog2(mm + 1) - 1;
    k    = p - 23;
`ifdef FPNR_SUBNORMAL_EN
    if (24 - e_in > k) k = 24 - e_in;
`endif
    if (k > 60) k = 60;
    if (k <= 0) begin
      q   = mm << (-k);
      inx = st;
      up  = 1'b0;
    end else begin
      q    = mm >> k;
      rem  = mm & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      inx  = (rem != 0) || st;
      up   = (rem > half) || (rem == half && (st || q[0]));
    end
    q = q + 64'(up);
    e = e_in + p - 46;
`ifdef FPNR_SUBNORMAL_EN
    if (e <= 0) return {s, q[30:0], 1'b0, inx, inx};
`endif
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 31'h7F800000, 3'b101};
    if (e <= 0) return {s, 31'b0, 3'b011};
    return {s, e[7:0], q[22:0], 2'b00, inx};
  endfunction

  task automatic drive_op(input logic s, input logic [EW-1:0] ex, input logic [MW-1:0] m,
                          input logic st, input logic [34:0] expv, input bit keep);
    int guard = 0;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = ex;
    in_mant   = m;
    in_sticky = st;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=in_ready=0 required=in_ready=1");
    end else if (keep) begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_op(output logic s, output logic [EW-1:0] ex, output logic [MW-1:0] m,
                         output logic st);
    logic [63:0] r;
    int ev;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0, 1:    ev = int'($urandom_range(0, 110)) - 60;
      2:       ev = int'($urandom_range(230, 300));
      3:       ev = int'($urandom_range(0, 1023)) - 512;
      default: ev = int'($urandom_range(60, 200));
    endcase
    ex = EW'(ev);
    r  = {$urandom, $urandom};
    m  = r[MW-1:0] >> $urandom_range(0, MW-1);
    if ($urandom_range(0, 19) == 0) m = '0;
    st = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (got_q.size() < exp_q.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    total++;
    if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h required=0", out_result); end
    total++;
    if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=000", {out_overflow, out_underflow, out_inexact});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int lat = 0;
    logic [34:0] e, g;
    in_valid  = 1'b1;
    in_sign   = 1'b0;
    in_exp    = 10'd127;
    in_mant   = 48'h1 << 46;
    in_sticky = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL latency_accept got=%b required=1", in_ready); end
    exp_q.push_back({32'h3F800000, 3'b000});
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    total++;
    if (lat != 3) begin bad++; $display("FAIL latency got=%0d required=3", lat); end
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL latency_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL latency_result got=%h required=%h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_directed();
    logic          d_s[11];
    logic [EW-1:0] d_e[11];
    logic [MW-1:0] d_m[11];
    logic          d_st[11];
    logic [34:0]   d_x[11];
    logic [34:0]   e, g;
    logic [MW-1:0] one46;
    one46 = 48'h1 << 46;
    d_s[0] = 0; d_e[0] = 10'd127; d_m[0] = 48'h900000000000;               d_st[0] = 0; d_x[0] = {32'h40100000, 3'b000};
    d_s[1] = 0; d_e[1] = 10'd127; d_m[1] = one46 | (48'h1 << 22);          d_st[1] = 0; d_x[1] = {32'h3F800000, 3'b001};
    d_s[2] = 0; d_e[2] = 10'd127; d_m[2] = one46 | (48'h3 << 22);          d_st[2] = 0; d_x[2] = {32'h3F800002, 3'b001};
    d_s[3] = 0; d_e[3] = 10'd254; d_m[3] = 48'hFFFFFFFFFFFF;               d_st[3] = 0; d_x[3] = {32'h7F800000, 3'b101};
    d_s[4] = 1; d_e[4] = 10'd254; d_m[4] = 48'hFFFFFFFFFFFF;               d_st[4] = 0; d_x[4] = {32'hFF800000, 3'b101};
    d_s[5] = 1; d_e[5] = 10'd50;  d_m[5] = 48'h0;                          d_st[5] = 1; d_x[5] = {32'h80000000, 3'b000};
    d_s[6] = 0; d_e[6] = 10'd127; d_m[6] = 48'hFFFFFFFFFFFF;               d_st[6] = 0; d_x[6] = {32'h40800000, 3'b001};
    d_s[7] = 0; d_e[7] = 10'd1;   d_m[7] = one46;                          d_st[7] = 0; d_x[7] = {32'h00800000, 3'b000};
    d_s[8] = 0; d_e[8] = 10'd127; d_m[8] = one46 | (48'h1 << 22);          d_st[8] = 1; d_x[8] = {32'h3F800001, 3'b001};
`ifdef FPNR_SUBNORMAL_EN
    d_s[9]  = 0; d_e[9]  = 10'd0;   d_m[9]  = one46; d_st[9]  = 0; d_x[9]  = {32'h00400000, 3'b000};
    d_s[10] = 0; d_e[10] = 10'h3FF; d_m[10] = one46; d_st[10] = 0; d_x[10] = {32'h00200000, 3'b000};
`else
    d_s[9]  = 0; d_e[9]  = 10'd0;   d_m[9]  = one46; d_st[9]  = 0; d_x[9]  = {32'h00000000, 3'b011};
    d_s[10] = 1; d_e[10] = 10'h3FF; d_m[10] = one46; d_st[10] = 0; d_x[10] = {32'h80000000, 3'b011};
`endif
    for (int i = 0; i < 11; i++) drive_op(d_s[i], d_e[i], d_m[i], d_st[i], d_x[i], 1'b1);
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL directed_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() != 0 && got_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL directed_%0d got=%h required=%h", i, g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic          s, st;
    logic [EW-1:0] ex;
    logic [MW-1:0] m;
    logic [34:0]   e, g;
    bit saw_stall = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rand_op(s, ex, m, st);
          drive_op(s, ex, m, st, model(s, ex, m, st), 1'b1);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1;
          if (c == 3) begin
            total++;
            if (!out_valid || got_q.size() != 0 ||
                {out_result, out_overflow, out_underflow, out_inexact} !== exp_q[0]) begin
              bad++;
              $display("FAIL stall_hold got=%b/%h required=1/%h", out_valid,
                       {out_result, out_overflow, out_underflow, out_inexact}, exp_q[0]);
            end
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    total++;
    if (!saw_stall) begin bad++; $display("FAIL stall_in_ready got=1 required=0"); end
    wait_drain();
    total++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() != 0 && got_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL b2b_%0d got=%h required=%h", i, g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    logic          s, st;
    logic [EW-1:0] ex;
    logic [MW-1:0] m;
    logic [34:0]   e, g;
    stim_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rand_op(s, ex, m, st);
          drive_op(s, ex, m, st, model(s, ex, m, st), 1'b1);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL random_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() != 0 && got_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL random_%0d got=%h required=%h", i, g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_inflight();
    drive_op(1'b0, 10'd127, 48'h1 << 46, 1'b0, 35'h0, 1'b0);
    drive_op(1'b1, 10'd130, 48'h3 << 45, 1'b0, 35'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight_reset_valid got=%b required=0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL inflight_leak got=%0d required=0", got_q.size()); end
    got_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_sticky = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
